// File: rtl/nios_audio_system_oci_dct_packer_pkg.sv
// Shared constants and types for the OCI DCT trace packer.
// Frame layout is {slot count, shift buffer}, newest code in the low bits.
package nios_oci_trace_pkg;

  localparam int DCT_CODE_W = 2;
  localparam int DCT_SLOTS  = 15;
  localparam int DCT_CNT_W  = 4;
  localparam int DCT_BUF_W  = DCT_CODE_W * DCT_SLOTS;
  localparam int FRM_W      = DCT_CNT_W + DCT_BUF_W;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic [DCT_CNT_W-1:0] cnt;
    logic [DCT_BUF_W-1:0] bits;
  } dct_frame_t;

endpackage

// File: rtl/nios_audio_system_oci_frame_reg.sv
// One-entry valid/ready holding register for sealed DCT frames.
// The packer only asserts load when the entry is empty or being drained this cycle.
module nios_audio_system_oci_frame_reg
  import nios_oci_trace_pkg::*;
#(
  parameter int W = FRM_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  out_state_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= OUT_EMPTY;
    else       state <= state_nxt;
  end

  // A load on the handshake cycle keeps the entry full, so frames go out without a bubble.
  always_comb begin
    state_nxt = state;
    if (load)                           state_nxt = OUT_FULL;
    else if (state == OUT_FULL && ready) state_nxt = OUT_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     data <= '0;
    else if (load) data <= load_data;
  end

  assign valid = (state == OUT_FULL);

endmodule

// File: rtl/nios_audio_system_oci_dct_packer.sv
// Packs 2-bit DCT codes from the retire stage into frames for the OCI trace writer.
// Frames seal on full, flush or trace disable; seals wait while the output entry is held.
module nios_audio_system_oci_dct_packer
  import nios_oci_trace_pkg::*;
#(
  parameter int CODE_W = DCT_CODE_W,
  parameter int SLOTS  = DCT_SLOTS,
  parameter int BUF_W  = CODE_W * SLOTS,
  parameter int CNT_W  = DCT_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trc_enable,
  input  logic                   dct_valid,
  input  logic [CODE_W-1:0]      dct_code,
  input  logic                   flush,
  output logic                   frm_valid,
  output logic [CNT_W+BUF_W-1:0] frm_data,
  input  logic                   frm_ready,
  output logic [BUF_W-1:0]       dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
  output logic                   overflow,
  input  logic                   ovf_clear
);

  localparam int               FW       = CNT_W + BUF_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  logic [BUF_W-1:0] buffer, buf_nxt, acc_buf;
  logic [CNT_W-1:0] count, cnt_nxt, acc_cnt;
  logic             en_q, flush_pend, pend_nxt;
  logic             take, free, flush_req, seal, drop, load;
  logic [FW-1:0]    load_data;

  assign take      = trc_enable & dct_valid;
  assign free      = ~frm_valid | frm_ready;
  // Disable falling edge behaves like a flush, including deferral.
  assign flush_req = flush | flush_pend | (en_q & ~trc_enable);

  always_comb begin
    buf_nxt   = buffer;
    cnt_nxt   = count;
    acc_buf   = buffer;
    acc_cnt   = count;
    seal      = 1'b0;
    drop      = 1'b0;
    load      = 1'b0;
    load_data = '0;
    pend_nxt  = 1'b0;
    if (count == FULL_CNT) begin
      // Deferred full frame: drain it as soon as the entry frees, new code starts a fresh buffer.
      if (free) begin
        load      = 1'b1;
        load_data = {count, buffer};
        buf_nxt   = '0;
        cnt_nxt   = '0;
        if (take) begin
          buf_nxt = BUF_W'(dct_code);
          cnt_nxt = CNT_W'(1);
        end
      end else begin
        drop     = take;
        pend_nxt = flush_req;
      end
    end else begin
      if (take) begin
        acc_buf = {buffer[BUF_W-CODE_W-1:0], dct_code};
        acc_cnt = count + CNT_W'(1);
      end
      seal    = (acc_cnt == FULL_CNT) | (flush_req & (acc_cnt != '0));
      buf_nxt = acc_buf;
      cnt_nxt = acc_cnt;
      if (seal) begin
        if (free) begin
          load      = 1'b1;
          load_data = {acc_cnt, acc_buf};
          buf_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          pend_nxt = flush_req;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer     <= '0;
      count      <= '0;
      en_q       <= 1'b0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      buffer     <= buf_nxt;
      count      <= cnt_nxt;
      en_q       <= trc_enable;
      flush_pend <= pend_nxt;
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  nios_audio_system_oci_frame_reg #(
    .W(FW)
  ) u_frame_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .ready     (frm_ready),
    .valid     (frm_valid),
    .data      (frm_data)
  );

  assign dct_buffer = buffer;
  assign dct_count  = count;

endmodule
